dsp_op_sequencer: RTL



---
 rtl/dsp_seq_pkg.sv | 31 +++
 rtl/dsp_seq_res_fifo.sv | 64 ++++++
 rtl/dsp_op_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dsp_seq_pkg                                                   |
// | Purpose  : Shared widths, sequencer state encoding and DSP48A1 opmode    |
// |            field constants for the DSP op sequencer.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package dsp_seq_pkg;

   // Slice port widths (fixed by the DSP48A1 primitive)
   localparam int W18 = 18;
   localparam int W48 = 48;
   localparam int W8  = 8;

   // Sequencer control states
   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   // Opmode fields: [1:0] X mux, [3:2] Z mux, then single-bit controls
   localparam logic [1:0] X_M       = 2'b01;
   localparam logic [1:0] Z_C       = 2'b11;
   localparam int         PREADD_EN = 4;
   localparam int         CIN_SEL   = 5;
   localparam int         PRE_SUB   = 6;
   localparam int         POST_SUB  = 7;

endpackage : dsp_seq_pkg
`default_nettype wire

// File: rtl/dsp_seq_res_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dsp_seq_res_fifo                                              |
// | Purpose  : Synchronous result FIFO. Head word is presented directly      |
// |            from storage; pointers carry an extra wrap bit so full and    |
// |            empty are distinguishable.                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dsp_seq_res_fifo #(
   parameter int DW    = 49,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic [DW-1:0]             push_data,
   input  logic                      pop,
   output logic [DW-1:0]             pop_data,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign do_pop   = pop && !empty;
   // Empty FIFO shows zero so the result port is clean out of reset
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Storage write; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointer update; push and pop in the same cycle leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Upstream credit accounting must make this unreachable
   a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule : dsp_seq_res_fifo
`default_nettype wire

// File: rtl/dsp_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dsp_op_sequencer                                              |
// | Purpose  : Command-side driver for a DSP48A1 slice. Registers accepted   |
// |            commands onto the slice inputs, tracks each op through the    |
// |            fixed slice pipeline and captures P/CARRYOUT into a result    |
// |            FIFO. Credit-based issue means a result is never dropped.     |
// | Options  : DSP_SEQ_TAG_EN - adds cmd_tag/res_tag carried with each op.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dsp_op_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int RES_DEPTH = 4
`ifdef DSP_SEQ_TAG_EN
   ,
   parameter int TAG_W     = 4
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [W8-1:0]    cmd_opmode,
   input  logic [W18-1:0]   cmd_a,
   input  logic [W18-1:0]   cmd_b,
   input  logic [W18-1:0]   cmd_d,
   input  logic [W48-1:0]   cmd_c,
   input  logic             cmd_carryin,
`ifdef DSP_SEQ_TAG_EN
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [TAG_W-1:0] res_tag,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W48-1:0]   res_p,
   output logic             res_carryout,
   output logic [W18-1:0]   dsp_a,
   output logic [W18-1:0]   dsp_b,
   output logic [W18-1:0]   dsp_d,
   output logic [W48-1:0]   dsp_c,
   output logic [W8-1:0]    dsp_opmode,
   output logic             dsp_carryin,
   output logic             dsp_rst,
   input  logic [W48-1:0]   dsp_p,
   input  logic             dsp_carryout
);

   localparam int CNT_W = $clog2(RES_DEPTH) + 1;
   localparam int SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;
`ifdef DSP_SEQ_TAG_EN
   localparam int DW    = W48 + 1 + TAG_W;
`else
   localparam int DW    = W48 + 1;
`endif

   seq_state_t       state;
   logic [4:0]       init_cnt;
   logic [LATENCY:0] vpipe;
   logic [4:0]       inflight;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             credit_ok;
   logic             accept;
   logic             push;
   logic [DW-1:0]    push_data;
   logic [DW-1:0]    head_data;

   // Ops in flight = number of set bits in the valid pipe
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LATENCY; i++) begin
         inflight = inflight + {4'd0, vpipe[i]};
      end
   end

   // Every in-flight op and every buffered result holds one FIFO slot
   assign credit_ok = (SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(RES_DEPTH);
   assign cmd_ready = (state == RUN) && credit_ok;
   assign accept    = cmd_valid && cmd_ready;
   assign push      = vpipe[LATENCY];

   // Control FSM: slice reset hold after reset release, run, and flush drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
         dsp_rst  <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               // dsp_rst drops after LATENCY+1 edges, RUN one edge later
               if (init_cnt == 5'(LATENCY)) begin
                  dsp_rst <= 1'b0;
               end
               if (init_cnt == 5'(LATENCY + 1)) begin
                  state <= RUN;
               end else begin
                  init_cnt <= init_cnt + 5'd1;
               end
            end
            RUN: begin
               dsp_rst <= 1'b0;
               if (flush) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               dsp_rst <= 1'b0;
               if (inflight == 5'd0) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   // Slice input registers: accepted command fields, otherwise a zero bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsp_a       <= '0;
         dsp_b       <= '0;
         dsp_d       <= '0;
         dsp_c       <= '0;
         dsp_opmode  <= '0;
         dsp_carryin <= 1'b0;
      end else if (accept) begin
         dsp_a       <= cmd_a;
         dsp_b       <= cmd_b;
         dsp_d       <= cmd_d;
         dsp_c       <= cmd_c;
         dsp_opmode  <= cmd_opmode;
         dsp_carryin <= cmd_carryin;
      end else begin
         dsp_a       <= '0;
         dsp_b       <= '0;
         dsp_d       <= '0;
         dsp_c       <= '0;
         dsp_opmode  <= '0;
         dsp_carryin <= 1'b0;
      end
   end

   // Valid pipe: bit0 marks the issue edge, top bit marks the capture edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
      end else begin
         vpipe <= {vpipe[LATENCY-1:0], accept};
      end
   end

`ifdef DSP_SEQ_TAG_EN
   logic [TAG_W-1:0] tag_pipe [LATENCY+1];

   // Tag pipe runs in lock-step with the valid pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= LATENCY; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= accept ? cmd_tag : '0;
         for (int i = 1; i <= LATENCY; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign push_data = {tag_pipe[LATENCY], dsp_carryout, dsp_p};
   assign res_tag   = head_data[DW-1 -: TAG_W];
`else
   assign push_data = {dsp_carryout, dsp_p};
`endif

   assign res_valid    = !fifo_empty;
   assign res_p        = head_data[W48-1:0];
   assign res_carryout = head_data[W48];

   dsp_seq_res_fifo #(
      .DW    (DW),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (res_ready),
      .pop_data  (head_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule : dsp_op_sequencer
`default_nettype wire
